tdm_demux4: RTL and testbench

- Receive end of a 4-channel time-division link. The transmit side is a 4:1 mux whose 2-bit select {s1,s0} rotates 0..3.
- This block re-aligns to the frame marker and decodes the slot number into one-hot write enables.
- It rebuilds the four parallel channels and publishes each completed frame atomically with a one-cycle strobe.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/decoder2_4.sv | 24 ++
 rtl/tdm_demux4.sv | 136 +++++++++++++
 tb/tb_tdm_demux4.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4-slot TDM receive path.
package tdm_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/decoder2_4.sv
// 2-to-4 one-hot decoder; receive-side mirror of the transmit mux select.
module decoder2_4
    import tdm_pkg::*;
(
    input  logic                 s1,
    input  logic                 s0,
    input  logic                 en,
    output logic [NUM_SLOTS-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            unique case ({s1, s0})
                2'd0: we = 4'b0001;
                2'd1: we = 4'b0010;
                2'd2: we = 4'b0100;
                2'd3: we = 4'b1000;
                default: we = '0;
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM receiver: frame alignment, slot staging, atomic frame publish.
// Optional even-parity checking on din is built when TDM_PARITY_EN is defined.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TDM_PARITY_EN
    input  logic [WIDTH:0]   din,
`else
    input  logic [WIDTH-1:0] din,
`endif
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_PARITY_EN
    ,
    output logic             par_err
`endif
);

    state_e                r_state;
    state_e                w_state_d;
    slot_t                 r_slot;
    slot_t                 w_slot_d;
    slot_t                 w_wr_slot;
    logic                  w_accept;
    logic                  w_sync_err_d;
    logic                  w_frame_ok;
    logic [NUM_SLOTS-1:0]  w_we;
    logic [WIDTH-1:0]      w_data;
    logic [WIDTH-1:0]      r_stage0;
    logic [WIDTH-1:0]      r_stage1;
    logic [WIDTH-1:0]      r_stage2;

    assign w_data = din[WIDTH-1:0];
    assign slot   = r_slot;
    assign locked = (r_state == LOCKED);

    // A sync word always restarts the frame at slot 0, even mid-frame.
    always_comb begin
        w_state_d    = r_state;
        w_slot_d     = r_slot;
        w_wr_slot    = r_slot;
        w_accept     = 1'b0;
        w_sync_err_d = 1'b0;
        if (din_valid) begin
            if (frame_sync) begin
                w_accept     = 1'b1;
                w_wr_slot    = '0;
                w_slot_d     = slot_t'(1);
                w_state_d    = LOCKED;
                w_sync_err_d = (r_state == LOCKED) && (r_slot != '0);
            end else if (r_state == LOCKED) begin
                if (r_slot == '0) begin
                    w_sync_err_d = 1'b1;
                    w_state_d    = HUNT;
                end else begin
                    w_accept = 1'b1;
                    w_slot_d = r_slot + slot_t'(1);
                end
            end
        end
    end

    decoder2_4 u_dec (
        .s1 (w_wr_slot[1]),
        .s0 (w_wr_slot[0]),
        .en (din_valid & w_accept),
        .we (w_we)
    );

`ifdef TDM_PARITY_EN
    logic w_par_bad;
    logic r_par_sticky;

    assign w_par_bad  = ^din;
    assign w_frame_ok = ~(r_par_sticky | w_par_bad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_sticky <= 1'b0;
            par_err      <= 1'b0;
        end else begin
            par_err <= (|w_we) & w_par_bad;
            if (w_we[0]) begin
                r_par_sticky <= w_par_bad;
            end else if (|w_we[3:1]) begin
                r_par_sticky <= r_par_sticky | w_par_bad;
            end
        end
    end
`else
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_slot      <= '0;
            r_stage0    <= '0;
            r_stage1    <= '0;
            r_stage2    <= '0;
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            ch3         <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_slot      <= w_slot_d;
            sync_err    <= w_sync_err_d;
            frame_valid <= w_we[3] & w_frame_ok;
            if (w_we[0]) r_stage0 <= w_data;
            if (w_we[1]) r_stage1 <= w_data;
            if (w_we[2]) r_stage2 <= w_data;
            if (w_we[3]) begin
                ch0 <= r_stage0;
                ch1 <= r_stage1;
                ch2 <= r_stage2;
                ch3 <= w_data;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=8).
module tb_tdm_demux4;

    localparam int unsigned WIDTH = 8;
`ifdef TDM_PARITY_EN
    localparam int unsigned DW = WIDTH + 1;
`else
    localparam int unsigned DW = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    din = '0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
    logic             frame_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;
`ifdef TDM_PARITY_EN
    logic             par_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_PARITY_EN
        ,
        .par_err     (par_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [WIDTH-1:0] d);
`ifdef TDM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [DW-1:0] w, input logic s);
        din        = w;
        frame_sync = s;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_ch(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        check({tag, "_ch0"}, 32'(ch0), e0);
        check({tag, "_ch1"}, 32'(ch1), e1);
        check({tag, "_ch2"}, 32'(ch2), e2);
        check({tag, "_ch3"}, 32'(ch3), e3);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_ch("rst", 0, 0, 0, 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_slot", 32'(slot), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_syncerr", 32'(sync_err), 0);
        rst = 1'b0;
        idle(1);

        // Lock and first frame
        send(mk(8'hA1), 1'b1);
        check("lock_locked", 32'(locked), 1);
        check("lock_slot1", 32'(slot), 1);
        send(mk(8'hB2), 1'b0);
        check("lock_slot2", 32'(slot), 2);
        send(mk(8'hC3), 1'b0);
        check("lock_slot3", 32'(slot), 3);
        check("lock_fv_pre", 32'(frame_valid), 0);
        send(mk(8'hD4), 1'b0);
        check("lock_fv", 32'(frame_valid), 1);
        check("lock_slot0", 32'(slot), 0);
        check_ch("lock", 32'hA1, 32'hB2, 32'hC3, 32'hD4);
        idle(1);
        check("lock_fv_pulse", 32'(frame_valid), 0);

        // Missing sync on slot 0
        send(mk(8'hEE), 1'b0);
        check("miss_syncerr", 32'(sync_err), 1);
        check("miss_locked", 32'(locked), 0);
        check("miss_fv", 32'(frame_valid), 0);
        check_ch("miss", 32'hA1, 32'hB2, 32'hC3, 32'hD4);
        idle(1);
        check("miss_syncerr_pulse", 32'(sync_err), 0);

        // HUNT ignores unsynced words
        send(mk(8'h11), 1'b0);
        check("hunt_syncerr", 32'(sync_err), 0);
        send(mk(8'h22), 1'b0);
        check("hunt_locked", 32'(locked), 0);
        check("hunt_slot", 32'(slot), 0);
        send(mk(8'h01), 1'b1);
        send(mk(8'h02), 1'b0);
        send(mk(8'h03), 1'b0);
        send(mk(8'h04), 1'b0);
        check("hunt_fv", 32'(frame_valid), 1);
        check_ch("hunt", 32'h01, 32'h02, 32'h03, 32'h04);

        // Stalls between words
        send(mk(8'h10), 1'b1);
        idle(3);
        check("stall_slot1", 32'(slot), 1);
        check("stall_fv1", 32'(frame_valid), 0);
        send(mk(8'h20), 1'b0);
        idle(3);
        check("stall_slot2", 32'(slot), 2);
        check("stall_hold_ch0", 32'(ch0), 32'h01);
        send(mk(8'h30), 1'b0);
        idle(3);
        check("stall_slot3", 32'(slot), 3);
        check("stall_fv3", 32'(frame_valid), 0);
        check("stall_hold_ch2", 32'(ch2), 32'h03);
        send(mk(8'h40), 1'b0);
        check("stall_fv", 32'(frame_valid), 1);
        check_ch("stall", 32'h10, 32'h20, 32'h30, 32'h40);

        // Early sync mid-frame
        send(mk(8'h55), 1'b1);
        send(mk(8'h66), 1'b0);
        check("early_slot2", 32'(slot), 2);
        send(mk(8'h77), 1'b1);
        check("early_syncerr", 32'(sync_err), 1);
        check("early_slot", 32'(slot), 1);
        check("early_locked", 32'(locked), 1);
        check("early_fv", 32'(frame_valid), 0);
        send(mk(8'h88), 1'b0);
        check("early_syncerr_pulse", 32'(sync_err), 0);
        send(mk(8'h99), 1'b0);
        send(mk(8'hAA), 1'b0);
        check("early_frame_fv", 32'(frame_valid), 1);
        check_ch("early", 32'h77, 32'h88, 32'h99, 32'hAA);

        // Back-to-back frame directly after
        send(mk(8'hBB), 1'b1);
        check("b2b_fv_off", 32'(frame_valid), 0);
        send(mk(8'hCC), 1'b0);
        send(mk(8'hDD), 1'b0);
        send(mk(8'hEF), 1'b0);
        check("b2b_fv", 32'(frame_valid), 1);
        check_ch("b2b", 32'hBB, 32'hCC, 32'hDD, 32'hEF);

`ifdef TDM_PARITY_EN
        // Bad parity on slot 2 suppresses frame_valid
        send(mk(8'h21), 1'b1);
        check("par_ok0", 32'(par_err), 0);
        send(mk(8'h22), 1'b0);
        send(9'h103, 1'b0);
        check("par_err", 32'(par_err), 1);
        send(mk(8'h24), 1'b0);
        check("par_err_pulse", 32'(par_err), 0);
        check("par_fv_supp", 32'(frame_valid), 0);
        check_ch("par", 32'h21, 32'h22, 32'h03, 32'h24);
        send(mk(8'h31), 1'b1);
        send(mk(8'h32), 1'b0);
        send(mk(8'h33), 1'b0);
        send(mk(8'h34), 1'b0);
        check("par_clean_fv", 32'(frame_valid), 1);
        check_ch("par_clean", 32'h31, 32'h32, 32'h33, 32'h34);
`endif

        // Reset mid-frame
        send(mk(8'h5A), 1'b1);
        send(mk(8'h5B), 1'b0);
        rst = 1'b1;
        #1;
        check_ch("midrst", 0, 0, 0, 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_slot", 32'(slot), 0);
        idle(1);
        rst = 1'b0;
        idle(2);
        check("midrst_fv", 32'(frame_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
